// File: rtl/cram_loader.sv
// Boot loader + instruction RAM: receives a length-prefixed program image over a byte stream,
// writes it to RAM, ACKs, then releases core reset. Optional checksum: define CRAM_LOADER_CHECKSUM_EN.
module cram_loader #(
  parameter int         DATA_W      = 32,
  parameter int         CRAM_ADDR_W = 10,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CRAM_ADDR_W-1:0] cram_addr,
  output logic [DATA_W-1:0]      cram_data,
  output logic                   core_nrst,
  output logic                   load_done,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             mmu_rx_data,
  output logic                   mmu_rx_valid,
  input  logic                   mmu_rx_ready,
  input  logic [7:0]             mmu_tx_data,
  input  logic                   mmu_tx_valid,
  output logic                   mmu_tx_ready
);

  localparam int          BPW       = DATA_W / 8;
  localparam int          BCW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int          DEPTH     = 2 ** CRAM_ADDR_W;
  localparam logic [16:0] MAX_WORDS = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_SUM, S_ACK, S_NAK, S_RUN
  } state_t;

  state_t                 state_q;
  logic                   rx_ready_q;
  logic                   tx_valid_q;
  logic [7:0]             tx_data_q;
  logic                   core_nrst_q;
  logic                   load_done_q;
  logic [7:0]             len_hi_q;
  logic [CRAM_ADDR_W:0]   len_q;
  logic [CRAM_ADDR_W:0]   wr_addr_q;
  logic [BCW-1:0]         byte_cnt_q;
  logic [DATA_W-1:0]      word_q;
  logic [DATA_W-1:0]      cram_data_q;
`ifdef CRAM_LOADER_CHECKSUM_EN
  logic [7:0]             xor_q;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic                 rx_fire;
  logic [15:0]          len_n;
  logic                 len_bad;
  logic [DATA_W-1:0]    word_d;
  logic [CRAM_ADDR_W:0] wr_addr_d;
  logic                 last_byte;
  logic                 last_word;
  logic                 mem_we;

  // rx_ready_q is only ever high in the receiving states, so this is a loader-side transfer.
  assign rx_fire   = rx_ready_q & rx_valid;
  assign len_n     = {len_hi_q, rx_data};
  assign len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS);
  assign word_d    = (word_q << 8) | DATA_W'(rx_data);
  assign wr_addr_d = wr_addr_q + {{CRAM_ADDR_W{1'b0}}, 1'b1};
  assign last_byte = (byte_cnt_q == BCW'(BPW - 1));
  assign last_word = (wr_addr_d == len_q);
  assign mem_we    = (state_q == S_DATA) && rx_fire && last_byte;

  // NOTE: the RAM array has no reset; its contents must survive rst, and a reset
  // on a memory array would also prevent it from mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q[CRAM_ADDR_W-1:0]] <= word_d;
  end

  always_ff @(posedge clk) begin
    if (rst) cram_data_q <= '0;
    else     cram_data_q <= mem[cram_addr];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN_HI;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      core_nrst_q <= 1'b0;
      load_done_q <= 1'b0;
      len_hi_q    <= 8'h00;
      len_q       <= '0;
      wr_addr_q   <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
`ifdef CRAM_LOADER_CHECKSUM_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      case (state_q)
        S_LEN_HI: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            len_hi_q <= rx_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_fire) begin
            if (len_bad) begin
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= NAK_BYTE;
              state_q    <= S_NAK;
            end else begin
              len_q      <= len_n[CRAM_ADDR_W:0];
              wr_addr_q  <= '0;
              byte_cnt_q <= '0;
`ifdef CRAM_LOADER_CHECKSUM_EN
              xor_q      <= 8'h00;
`endif
              state_q    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            word_q <= word_d;
`ifdef CRAM_LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ rx_data;
`endif
            if (last_byte) begin
              byte_cnt_q <= '0;
              wr_addr_q  <= wr_addr_d;
              if (last_word) begin
`ifdef CRAM_LOADER_CHECKSUM_EN
                state_q    <= S_SUM;
`else
                rx_ready_q <= 1'b0;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ACK_BYTE;
                state_q    <= S_ACK;
`endif
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end
        end
`ifdef CRAM_LOADER_CHECKSUM_EN
        S_SUM: begin
          if (rx_fire) begin
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b1;
            if (rx_data == xor_q) begin
              tx_data_q <= ACK_BYTE;
              state_q   <= S_ACK;
            end else begin
              tx_data_q <= NAK_BYTE;
              state_q   <= S_NAK;
            end
          end
        end
`endif
        S_ACK: begin
          if (tx_ready) begin
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            core_nrst_q <= 1'b1;
            load_done_q <= 1'b1;
            state_q     <= S_RUN;
          end
        end
        S_NAK: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ready_q <= 1'b1;
            state_q    <= S_LEN_HI;
          end
        end
        S_RUN: begin
          // Terminal until rst; all traffic is passed straight through.
        end
        default: state_q <= S_LEN_HI;
      endcase
    end
  end

  // load_done_q is high exactly in RUN, so it selects loader vs passthrough.
  assign cram_data    = cram_data_q;
  assign core_nrst    = core_nrst_q;
  assign load_done    = load_done_q;
  assign rx_ready     = load_done_q ? mmu_rx_ready : rx_ready_q;
  assign tx_valid     = load_done_q ? mmu_tx_valid : tx_valid_q;
  assign tx_data      = load_done_q ? mmu_tx_data  : tx_data_q;
  assign mmu_rx_data  = rx_data;
  assign mmu_rx_valid = load_done_q & rx_valid;
  assign mmu_tx_ready = load_done_q & tx_ready;

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader (DATA_W=32, CRAM_ADDR_W=4): table of load scenarios plus
// hand-written sequences for backpressure, passthrough, reset mid-load and checksum.
module tb_cram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cram_addr = '0;
  logic [31:0] cram_data;
  logic        core_nrst, load_done;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  mmu_rx_data;
  logic        mmu_rx_valid;
  logic        mmu_rx_ready = 1'b0;
  logic [7:0]  mmu_tx_data = '0;
  logic        mmu_tx_valid = 1'b0;
  logic        mmu_tx_ready;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] sum_acc;

  cram_loader #(.DATA_W(32), .CRAM_ADDR_W(4), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rst(rst),
    .cram_addr(cram_addr), .cram_data(cram_data),
    .core_nrst(core_nrst), .load_done(load_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mmu_rx_data(mmu_rx_data), .mmu_rx_valid(mmu_rx_valid), .mmu_rx_ready(mmu_rx_ready),
    .mmu_tx_data(mmu_tx_data), .mmu_tx_valid(mmu_tx_valid), .mmu_tx_ready(mmu_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold rst for two edges and verify the reset values while it is asserted.
  task automatic reset_dut();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_core_nrst", core_nrst, 0);
    check("rst_load_done", load_done, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_cram_data", cram_data, 0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rx_accept_timeout", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    sum_acc = 8'h00;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[i*8 +: 8];
      sum_acc = sum_acc ^ b;
      send_byte(b);
    end
  endtask

  task automatic send_sum();
`ifdef CRAM_LOADER_CHECKSUM_EN
    send_byte(sum_acc);
`endif
  endtask

  // Wait (bounded) for tx_valid, compare the byte, then let the handshake complete.
  task automatic expect_tx(input string name, input logic [7:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, tx_valid, 1);
    check({name, "_data"}, tx_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    cram_addr = a;
    @(posedge clk); #1;
    check(name, cram_data, exp);
  endtask

  typedef struct {
    string       name;
    logic        do_rst;
    logic [15:0] n;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  exp_tx;
    logic        exp_run;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{"basic", 1'b1, 16'h0002, 2, 32'hDEADBEEF, 32'h12345678, 8'h06, 1'b1};
    vecs[1] = '{"len0",  1'b1, 16'h0000, 0, 32'h0,       32'h0,        8'h15, 1'b0};
    vecs[2] = '{"len17", 1'b0, 16'h0011, 0, 32'h0,       32'h0,        8'h15, 1'b0};

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].do_rst) reset_dut();
      send_hdr(vecs[i].n);
      if (vecs[i].nw > 0) send_word(vecs[i].w0);
      if (vecs[i].nw > 1) send_word(vecs[i].w1);
      if (vecs[i].nw > 0) send_sum();
      expect_tx({vecs[i].name, "_tx"}, vecs[i].exp_tx);
      check({vecs[i].name, "_core_nrst"}, core_nrst, vecs[i].exp_run);
      check({vecs[i].name, "_load_done"}, load_done, vecs[i].exp_run);
      // mmu_rx_ready is 0: in RUN rx_ready follows it, in LEN_HI the loader is ready.
      check({vecs[i].name, "_rx_ready"}, rx_ready, !vecs[i].exp_run);
      if (vecs[i].exp_run) begin
        read_check({vecs[i].name, "_rd1"}, 4'd1, vecs[i].w1);
        read_check({vecs[i].name, "_rd0"}, 4'd0, vecs[i].w0);
      end
    end

    // Full 16-word load right after the two NAKs fills the RAM exactly.
    send_hdr(16'h0010);
    for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + i * 32'h0101_0101);
    send_sum();
    expect_tx("full_tx", 8'h06);
    check("full_core_nrst", core_nrst, 1);
    read_check("full_rd15", 4'd15, 32'hA000_0000 + 15 * 32'h0101_0101);
    read_check("full_rd0", 4'd0, 32'hA000_0000);

    // ACK backpressure: output held, rx refused, MMU stalled, core held in reset.
    begin
      int bad;
      bad = 0;
      reset_dut();
      tx_ready = 1'b0;
      send_hdr(16'h0001);
      send_word(32'hAABBCCDD);
      send_sum();
      rx_data  = 8'h77;
      rx_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!tx_valid || tx_data !== 8'h06 || rx_ready || core_nrst || mmu_rx_valid || load_done)
          bad++;
      end
      check("bp_hold_bad_cycles", bad, 0);
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_core_nrst", core_nrst, 1);
      check("bp_tx_idle", tx_valid, 0);
    end

    // Passthrough in RUN.
    rx_data = 8'h41;
    rx_valid = 1'b1;
    mmu_rx_ready = 1'b1;
    #1;
    check("pt_mmu_rx_data", mmu_rx_data, 8'h41);
    check("pt_mmu_rx_valid", mmu_rx_valid, 1);
    check("pt_rx_ready", rx_ready, 1);
    rx_valid = 1'b0;
    mmu_rx_ready = 1'b0;
    mmu_tx_data = 8'h5A;
    mmu_tx_valid = 1'b1;
    tx_ready = 1'b0;
    #1;
    check("pt_tx_valid", tx_valid, 1);
    check("pt_tx_data", tx_data, 8'h5A);
    check("pt_mmu_tx_ready", mmu_tx_ready, 0);
    tx_ready = 1'b1;
    #1;
    check("pt_mmu_tx_ready_hi", mmu_tx_ready, 1);
    mmu_tx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-load, then a clean one-word load.
    reset_dut();
    send_hdr(16'h0002);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    reset_dut();
    check("midrst_core_nrst", core_nrst, 0);
    send_hdr(16'h0001);
    send_word(32'hCAFEF00D);
    send_sum();
    expect_tx("reload_tx", 8'h06);
    check("reload_core_nrst", core_nrst, 1);
    read_check("reload_rd0", 4'd0, 32'hCAFEF00D);

`ifdef CRAM_LOADER_CHECKSUM_EN
    reset_dut();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    expect_tx("sum_good_tx", 8'h06);
    check("sum_good_core_nrst", core_nrst, 1);
    reset_dut();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    expect_tx("sum_bad_tx", 8'h15);
    check("sum_bad_core_nrst", core_nrst, 0);
    check("sum_bad_rx_ready", rx_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
